// File: rtl/idec_pkg.sv
// rtl/idec_pkg.sv - shared decode types, opcodes and the decoded-entry record
package idec_pkg;

    localparam int XLEN_MAX = 64;
    localparam int REG_MAX  = 5;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_BAD = 3'd7
    } fmt_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Held at the widest legal sizes; the stage truncates to its parameters.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [REG_MAX-1:0]  rd;
        logic [REG_MAX-1:0]  rs1;
        logic [REG_MAX-1:0]  rs2;
        logic [19:0]         inp;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
    } dec_t;

    function automatic logic reg_oob(input logic [REG_MAX-1:0] idx, input int width);
        return (idx >> width) != '0;
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and decode-side handshake bundle
interface instr_decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_pc;
    logic [6:0]            out_opcode;
    logic [2:0]            out_funct3;
    logic [6:0]            out_funct7;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [REG_ADDR_W-1:0] out_rs1;
    logic [REG_ADDR_W-1:0] out_rs2;
    logic [19:0]           out_inp;
    logic [XLEN-1:0]       out_imm;
    logic [2:0]            out_fmt;
    logic                  out_illegal;
    logic                  halted;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_inp, out_imm, out_fmt, out_illegal, halted
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_inp, out_imm, out_fmt, out_illegal, halted
    );
endinterface

// File: rtl/idec_comb.sv
// rtl/idec_comb.sv - combinational split of one instruction into a decoded entry
module idec_comb
    import idec_pkg::*;
#(
    parameter int         REG_ADDR_W = 5,
    parameter logic [6:0] HALT_OP    = 7'b1010101,
    parameter logic [6:0] LDIMM_OP   = 7'b1111111
) (
    input  logic [31:0]         instr,
    input  logic [XLEN_MAX-1:0] pc,
    output dec_t                dec
);

    logic use_rd;
    logic use_rs1;
    logic use_rs2;

    always_comb begin
        dec        = '0;
        use_rd     = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.pc     = pc;
        dec.opcode = instr[6:0];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.inp    = instr[31:12];
        dec.fmt    = FMT_BAD;
        dec.imm    = '0;

        // Custom opcodes are matched first so they cannot alias a base format.
        if (instr[6:0] == HALT_OP) begin
            dec.fmt = FMT_SYS;
        end else if (instr[6:0] == LDIMM_OP) begin
            dec.fmt = FMT_SYS;
            dec.imm = {44'b0, instr[31:12]};
            use_rd  = 1'b1;
        end else begin
            case (instr[6:0])
                OP_R: begin
                    dec.fmt = FMT_R;
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_I, OP_LOAD, OP_JALR: begin
                    dec.fmt = FMT_I;
                    dec.imm = {{52{instr[31]}}, instr[31:20]};
                    use_rd  = 1'b1;
                    use_rs1 = 1'b1;
                end
                OP_S: begin
                    dec.fmt = FMT_S;
                    dec.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_B: begin
                    dec.fmt = FMT_B;
                    dec.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    dec.fmt = FMT_U;
                    dec.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
                    use_rd  = 1'b1;
                end
                OP_JAL: begin
                    dec.fmt = FMT_J;
                    dec.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    use_rd  = 1'b1;
                end
                default: dec.fmt = FMT_BAD;
            endcase
        end

        dec.illegal = (dec.fmt == FMT_BAD)
                    | (use_rd  & reg_oob(instr[11:7],  REG_ADDR_W))
                    | (use_rs1 & reg_oob(instr[19:15], REG_ADDR_W))
                    | (use_rs2 & reg_oob(instr[24:20], REG_ADDR_W));
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered decode stage with skid buffer and halt FSM
module instr_decode_stage
    import idec_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter int         REG_ADDR_W = 5,
    parameter logic [6:0] HALT_OP    = 7'b1010101,
    parameter logic [6:0] LDIMM_OP   = 7'b1111111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    instr_decode_stage_if.slave   io
);

    dec_t   dec;
    dec_t   out_q, out_d;
    dec_t   skid_q, skid_d;
    logic   out_v, out_v_d;
    logic   skid_v, skid_v_d;
    logic   rdy_q, rdy_d;
    logic   accept;
    state_e state, state_d;

    idec_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .HALT_OP    (HALT_OP),
        .LDIMM_OP   (LDIMM_OP)
    ) u_comb (
        .instr (io.in_instr),
        .pc    (XLEN_MAX'(io.in_pc)),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
            state  <= ST_RUN;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
            out_v  <= out_v_d;
            skid_v <= skid_v_d;
            rdy_q  <= rdy_d;
            state  <= state_d;
        end
    end

    always_comb begin
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v;
        skid_v_d = skid_v;
        state_d  = state;
        accept   = io.in_valid && rdy_q;

        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
            state_d  = ST_RUN;
        end else begin
            // Output slot free or draining: skid entry is older, so it goes first.
            if (!out_v || io.out_ready) begin
                if (skid_v) begin
                    out_d    = skid_q;
                    out_v_d  = 1'b1;
                    skid_v_d = 1'b0;
                end else if (accept) begin
                    out_d   = dec;
                    out_v_d = 1'b1;
                end else begin
                    out_v_d = 1'b0;
                end
            end else if (accept) begin
                skid_d   = dec;
                skid_v_d = 1'b1;
            end
            if (accept && dec.opcode == HALT_OP) begin
                state_d = ST_HALTED;
            end
        end

        // Registered ready looks only at next-state, never at out_ready directly.
        rdy_d = !skid_v_d && (state_d == ST_RUN);
    end

    assign io.in_ready    = rdy_q;
    assign io.out_valid   = out_v;
    assign io.out_pc      = out_q.pc[XLEN-1:0];
    assign io.out_opcode  = out_q.opcode;
    assign io.out_funct3  = out_q.funct3;
    assign io.out_funct7  = out_q.funct7;
    assign io.out_rd      = out_q.rd[REG_ADDR_W-1:0];
    assign io.out_rs1     = out_q.rs1[REG_ADDR_W-1:0];
    assign io.out_rs2     = out_q.rs2[REG_ADDR_W-1:0];
    assign io.out_inp     = out_q.inp;
    assign io.out_imm     = out_q.imm[XLEN-1:0];
    assign io.out_fmt     = out_q.fmt;
    assign io.out_illegal = out_q.illegal;
    assign io.halted      = (state == ST_HALTED);

    // Upper bits of the wide record are dropped when the parameters are narrower.
    logic unused_hi;
    assign unused_hi = ^{out_q.pc, out_q.imm, out_q.rd, out_q.rs1, out_q.rs2};

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed vector and sequence bench for instr_decode_stage
module tb_instr_decode_stage;

    logic clk;
    logic rst_n;
    logic flush;

    instr_decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    instr_decode_stage_if #(.XLEN(32), .REG_ADDR_W(4)) bus4 ();

    instr_decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (bus.slave)
    );

    instr_decode_stage #(.XLEN(32), .REG_ADDR_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (bus4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [19:0] inp;
        logic        ill;
    } vec_t;

    vec_t vecs[12];
    int total = 0;
    int bad   = 0;
    logic [31:0] log_q[$];

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) log_q.push_back(bus.out_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, output bit ok);
        bus.in_instr = ins;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want accept of %h", ins);
        end
    endtask

    initial begin
        bit ok;
        vecs[0]  = '{32'h009400B3, 32'h1000, 3'd0, 32'h00000000,  5'd1,  5'd8,  5'd9, 3'd0, 20'h00940, 1'b0};
        vecs[1]  = '{32'hFFF40093, 32'h1004, 3'd1, 32'hFFFFFFFF,  5'd1,  5'd8, 5'd31, 3'd0, 20'hFFF40, 1'b0};
        vecs[2]  = '{32'hFE940EE3, 32'h1008, 3'd3, 32'hFFFFFFFC, 5'd29,  5'd8,  5'd9, 3'd0, 20'hFE940, 1'b0};
        vecs[3]  = '{32'hFE942C23, 32'h100C, 3'd2, 32'hFFFFFFF8, 5'd24,  5'd8,  5'd9, 3'd2, 20'hFE942, 1'b0};
        vecs[4]  = '{32'h123452B7, 32'h1010, 3'd4, 32'h12345000,  5'd5,  5'd8,  5'd3, 3'd5, 20'h12345, 1'b0};
        vecs[5]  = '{32'h0080006F, 32'h1014, 3'd5, 32'h00000008,  5'd0,  5'd0,  5'd8, 3'd0, 20'h00800, 1'b0};
        vecs[6]  = '{32'hFFDFF0EF, 32'h1018, 3'd5, 32'hFFFFFFFC,  5'd1, 5'd31, 5'd29, 3'd7, 20'hFFDFF, 1'b0};
        vecs[7]  = '{32'h80000017, 32'h101C, 3'd4, 32'h80000000,  5'd0,  5'd0,  5'd0, 3'd0, 20'h80000, 1'b0};
        vecs[8]  = '{32'h00442083, 32'h1020, 3'd1, 32'h00000004,  5'd1,  5'd8,  5'd4, 3'd2, 20'h00442, 1'b0};
        vecs[9]  = '{32'h000080E7, 32'h1024, 3'd1, 32'h00000000,  5'd1,  5'd1,  5'd0, 3'd0, 20'h00008, 1'b0};
        vecs[10] = '{32'h0000000B, 32'h1028, 3'd7, 32'h00000000,  5'd0,  5'd0,  5'd0, 3'd0, 20'h00000, 1'b1};
        vecs[11] = '{32'hFFFFF07F, 32'h102C, 3'd6, 32'h000FFFFF,  5'd0, 5'd31, 5'd31, 3'd7, 20'hFFFFF, 1'b0};

        rst_n = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_instr = '0; bus4.in_pc = '0; bus4.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.in_ready", bus.in_ready, 0);
        chk("rst.halted", bus.halted, 0);
        chk("rst.out_pc", bus.out_pc, 0);
        rst_n = 1'b1;
        chk("rel.in_ready_before_edge", bus.in_ready, 0);
        step();
        chk("rel.in_ready_after_edge", bus.in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].instr, vecs[i].pc, ok);
            chk($sformatf("v%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("v%0d.pc", i), bus.out_pc, vecs[i].pc);
            chk($sformatf("v%0d.fmt", i), bus.out_fmt, vecs[i].fmt);
            chk($sformatf("v%0d.imm", i), bus.out_imm, vecs[i].imm);
            chk($sformatf("v%0d.rd", i), bus.out_rd, vecs[i].rd);
            chk($sformatf("v%0d.rs1", i), bus.out_rs1, vecs[i].rs1);
            chk($sformatf("v%0d.rs2", i), bus.out_rs2, vecs[i].rs2);
            chk($sformatf("v%0d.f3", i), bus.out_funct3, vecs[i].f3);
            chk($sformatf("v%0d.inp", i), bus.out_inp, vecs[i].inp);
            chk($sformatf("v%0d.ill", i), bus.out_illegal, vecs[i].ill);
            if (i == 0) begin
                chk("add.funct7", bus.out_funct7, 0);
                chk("add.opcode", bus.out_opcode, 7'h33);
            end
        end
        step();
        chk("drain.out_valid", bus.out_valid, 0);

        // Skid: three back-to-back, downstream stalls for two cycles.
        log_q.delete();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h009400B3; bus.in_pc = 32'h2000;
        step();
        bus.out_ready = 1'b0; bus.in_pc = 32'h2004;
        step();
        chk("skid.in_ready_full", bus.in_ready, 0);
        chk("skid.hold_pc1", bus.out_pc, 32'h2000);
        bus.in_pc = 32'h2008;
        step();
        chk("skid.hold_pc2", bus.out_pc, 32'h2000);
        chk("skid.hold_valid", bus.out_valid, 1);
        chk("skid.in_ready_still", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        chk("skid.drain_pc", bus.out_pc, 32'h2004);
        chk("skid.in_ready_back", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("skid.third_pc", bus.out_pc, 32'h2008);
        step();
        chk("skid.empty", bus.out_valid, 0);
        chk("skid.count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("skid.order0", log_q[0], 32'h2000);
            chk("skid.order1", log_q[1], 32'h2004);
            chk("skid.order2", log_q[2], 32'h2008);
        end

        // HALT: emitted, then intake closed until flush.
        log_q.delete();
        send(32'h00000055, 32'h3000, ok);
        chk("halt.valid", bus.out_valid, 1);
        chk("halt.fmt", bus.out_fmt, 3'd6);
        chk("halt.imm", bus.out_imm, 0);
        chk("halt.halted", bus.halted, 1);
        chk("halt.in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h009400B3; bus.in_pc = 32'h3004;
        step();
        step();
        step();
        chk("halt.in_ready_held", bus.in_ready, 0);
        chk("halt.drained", bus.out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush.halted", bus.halted, 0);
        chk("flush.in_ready", bus.in_ready, 1);
        chk("flush.out_valid", bus.out_valid, 0);
        step();
        chk("halt.log_count", log_q.size(), 1);
        if (log_q.size() >= 1) chk("halt.log_pc", log_q[0], 32'h3000);

        // Flush beats a same-cycle accept.
        log_q.delete();
        bus.in_valid = 1'b1; bus.in_pc = 32'h4000; flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flushwin.out_valid", bus.out_valid, 0);
        chk("flushwin.in_ready", bus.in_ready, 1);
        step();
        chk("flushwin.log", log_q.size(), 0);

        // Narrow register index: only fields the format uses are range-checked.
        bus4.in_valid = 1'b1; bus4.in_instr = 32'h009408B3; bus4.in_pc = 32'h5000;
        step();
        chk("w4.add_ill", bus4.out_illegal, 1);
        chk("w4.add_rd", bus4.out_rd, 4'd1);
        chk("w4.add_fmt", bus4.out_fmt, 3'd0);
        bus4.in_instr = 32'h0000107F;
        step();
        chk("w4.ldimm_fmt", bus4.out_fmt, 3'd6);
        chk("w4.ldimm_imm", bus4.out_imm, 32'h1);
        chk("w4.ldimm_ill", bus4.out_illegal, 0);
        bus4.in_instr = 32'hFFDFF0EF;
        step();
        chk("w4.jal_ill", bus4.out_illegal, 0);
        bus4.in_instr = 32'hFFF40093;
        step();
        bus4.in_valid = 1'b0;
        chk("w4.addi_ill", bus4.out_illegal, 0);
        chk("w4.addi_rs2", bus4.out_rs2, 4'hF);

        // Reset while output valid and skid full.
        log_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h009400B3; bus.in_pc = 32'h6000;
        step();
        bus.in_pc = 32'h6004;
        step();
        bus.in_valid = 1'b0;
        chk("mid.full", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_valid", bus.out_valid, 0);
        chk("mid.rst_pc", bus.out_pc, 0);
        chk("mid.rst_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("mid.rel_ready", bus.in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mid.no_stale%0d", c), bus.out_valid, 0);
            step();
        end
        chk("mid.log", log_q.size(), 0);
        send(32'h009400B3, 32'h7000, ok);
        chk("mid.after_pc", bus.out_pc, 32'h7000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
